// File: rtl/data_sram_resp_if.sv
// Data SRAM bus between the core (master) and its responder (slave).
// One access per cycle; read data comes back one cycle later on data_sram_rdata.
interface data_sram_resp_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en,
      output data_sram_we,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_we,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_resp.sv
// Data SRAM responder: word RAM plus a small MMIO block (LED, switch, timer, scratch).
// Reads are read-first with a fixed one-cycle latency; RAM contents survive reset.
module data_sram_resp #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] MMIO_BASE  = 32'hBFAF_0000
) (
   input  logic             clk,
   input  logic             resetn,
   data_sram_resp_if.slave  bus,
   output logic [15:0]      led,
   input  logic [7:0]       switch
);

   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [31:0] mem [Depth];

   logic [31:0] rdata_q, rdata_d;
   logic [15:0] led_q, led_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] scratch_q, scratch_d;
   logic [7:0]  sw_meta_q, sw_sync_q;

   logic                  is_mmio;
   logic [13:0]           mmio_off;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  sel_led, sel_timer, sel_scratch;
   logic                  ram_we;
   logic [31:0]           rd_val;
   logic                  unused_addr;

   function automatic logic [31:0] merge_lanes(logic [31:0] old_val, logic [31:0] new_val,
                                                logic [3:0] we);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

   assign is_mmio     = bus.data_sram_addr[31:16] == MMIO_BASE[31:16];
   assign mmio_off    = bus.data_sram_addr[15:2];
   assign word_idx    = bus.data_sram_addr[ADDR_WIDTH+1:2];
   assign unused_addr = ^bus.data_sram_addr[1:0];
   assign sel_led     = is_mmio && (mmio_off == 14'h0);
   assign sel_timer   = is_mmio && (mmio_off == 14'h2);
   assign sel_scratch = is_mmio && (mmio_off == 14'h3);
   assign ram_we      = bus.data_sram_en && !is_mmio;

   always_comb begin
      rd_val = 32'h0;
      if (!is_mmio) begin
         rd_val = mem[word_idx];
      end else begin
         unique case (mmio_off)
            14'h0:   rd_val = {16'h0, led_q};
            14'h1:   rd_val = {24'h0, sw_sync_q};
            14'h2:   rd_val = timer_q;
            14'h3:   rd_val = scratch_q;
            default: rd_val = 32'h0;
         endcase
      end
   end

   always_comb begin
      rdata_d   = bus.data_sram_en ? rd_val : rdata_q;
      led_d     = led_q;
      timer_d   = timer_q + 32'd1;
      scratch_d = scratch_q;
      if (bus.data_sram_en && sel_led) begin
         if (bus.data_sram_we[0]) led_d[7:0]  = bus.data_sram_wdata[7:0];
         if (bus.data_sram_we[1]) led_d[15:8] = bus.data_sram_wdata[15:8];
      end
      // A timer write loads the merged value as-is; counting resumes the cycle after.
      if (bus.data_sram_en && sel_timer && |bus.data_sram_we) begin
         timer_d = merge_lanes(timer_q, bus.data_sram_wdata, bus.data_sram_we);
      end
      if (bus.data_sram_en && sel_scratch) begin
         scratch_d = merge_lanes(scratch_q, bus.data_sram_wdata, bus.data_sram_we);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_q   <= 32'h0;
         led_q     <= 16'h0;
         timer_q   <= 32'h0;
         scratch_q <= 32'h0;
         sw_meta_q <= 8'h0;
         sw_sync_q <= 8'h0;
      end else begin
         rdata_q   <= rdata_d;
         led_q     <= led_d;
         timer_q   <= timer_d;
         scratch_q <= scratch_d;
         sw_meta_q <= switch;
         sw_sync_q <= sw_meta_q;
      end
   end

   // RAM array has no reset so its contents survive a reset pulse.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ram_we && bus.data_sram_we[i]) begin
            mem[word_idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   assign bus.data_sram_rdata = rdata_q;
   assign led                 = led_q;

endmodule
